// File: rtl/tl_tx_pkt_drain.sv
// -----------------------------------------------------------------------------
// tl_tx_pkt_drain
//
// Purpose:
//   Drains 256-bit beats from the transaction-layer FIFO (combinational-read
//   mode: head word valid whenever not empty, pop advances it), frames each
//   TLP with sop/eop using the length in the header of beat 0, and holds a
//   packet at the head of line until enough header and data flow-control
//   credits are available. Credits are consumed at the sop handshake and
//   replenished by the return inputs, saturating at their maximums.
//
// Optional feature:
//   `define TL_TX_DRAIN_STATS_EN to add a wrapping completed-packet counter
//   (debug_o[15:8]) and a saturating credit-blocked-cycle counter
//   (debug_o[7:0]). Without the macro those bits read 0 and no counter flops
//   exist.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   fifo_empty_i    FIFO empty flag
//   fifo_rden_o     FIFO pop (asserted on every output handshake)
//   fifo_rdata_i    FIFO head word
//   tx_valid_o      output beat valid
//   tx_ready_i      downstream ready
//   tx_data_o       output beat (the FIFO head word)
//   tx_sop_o        first beat of a TLP
//   tx_eop_o        last beat of a TLP
//   hdr_crd_ret_i   return one header credit
//   dat_crd_ret_i   return 0..15 data credits
//   hdr_crd_o       current header credits
//   dat_crd_o       current data credits
//   debug_o         [31] in XFER, [30] credit-blocked, [29] sticky credit
//                   overflow, [28] sticky FIFO-empty in XFER, [23:16]
//                   remaining beats, [15:0] stats (optional) or 0
//
// Stream handshake: a beat transfers on a cycle where tx_valid_o and
// tx_ready_i are both high. Valid, once raised, stays high with stable data
// until that handshake; the only way it can drop is the FIFO going empty,
// which cannot happen while the head word is still unpopped.
// -----------------------------------------------------------------------------
module tl_tx_pkt_drain #(
    parameter int DATA_WIDTH  = 256,
    parameter int HDR_CRD_MAX = 8,
    parameter int DAT_CRD_MAX = 64,
    parameter int CRD_W       = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fifo_empty_i,
    output logic                  fifo_rden_o,
    input  logic [DATA_WIDTH-1:0] fifo_rdata_i,
    output logic                  tx_valid_o,
    input  logic                  tx_ready_i,
    output logic [DATA_WIDTH-1:0] tx_data_o,
    output logic                  tx_sop_o,
    output logic                  tx_eop_o,
    input  logic                  hdr_crd_ret_i,
    input  logic [3:0]            dat_crd_ret_i,
    output logic [CRD_W-1:0]      hdr_crd_o,
    output logic [CRD_W-1:0]      dat_crd_o,
    output logic [31:0]           debug_o
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        XFER = 1'b1
    } state_t;

    state_t             state;
    logic [7:0]         remaining;
    logic [CRD_W-1:0]   hdr_crd;
    logic [CRD_W-1:0]   dat_crd;
    logic               ovf_sticky;
    logic               empty_sticky;

    // Header decode (only meaningful in IDLE, when the head word is beat 0)
    logic               has_data;
    logic [9:0]         len_dw;
    logic [10:0]        len_full;
    logic [10:0]        pay_beats;
    logic               crd_ok;
    logic               go;
    logic               blocked;
    logic               hs;
    logic               sop_hs;
    logic               eop_hs;

    // Credit update arithmetic, wide enough to hold cur + return before
    // saturation.
    logic [11:0]        hdr_sum;
    logic [11:0]        dat_sum;
    logic [11:0]        dat_take;
    logic               hdr_ovf;
    logic               dat_ovf;

    always_comb begin
        has_data  = fifo_rdata_i[30];
        len_dw    = fifo_rdata_i[9:0];
        len_full  = (len_dw == 10'd0) ? 11'd1024 : {1'b0, len_dw};
        pay_beats = has_data ? ((len_full + 11'd7) >> 3) : 11'd0;

        // Go check sees only registered credits; same-cycle returns count
        // from the next cycle on.
        crd_ok  = (hdr_crd != '0) && (12'(dat_crd) >= {1'b0, pay_beats});
        go      = (state == IDLE) && !fifo_empty_i && crd_ok;
        blocked = (state == IDLE) && !fifo_empty_i && !crd_ok;
    end

    always_comb begin
        tx_valid_o = 1'b0;
        tx_sop_o   = 1'b0;
        tx_eop_o   = 1'b0;
        if (state == IDLE) begin
            tx_valid_o = go;
            tx_sop_o   = go;
            tx_eop_o   = go && (pay_beats == 11'd0);
        end else begin
            tx_valid_o = !fifo_empty_i;
            tx_eop_o   = !fifo_empty_i && (remaining == 8'd1);
        end
        hs          = tx_valid_o && tx_ready_i;
        sop_hs      = tx_sop_o && hs;
        eop_hs      = tx_eop_o && hs;
        fifo_rden_o = hs;
        tx_data_o   = fifo_rdata_i;
    end

    always_comb begin
        dat_take = sop_hs ? {1'b0, pay_beats} : 12'd0;
        // Consumption only happens when credits cover it, so no underflow.
        hdr_sum  = 12'(hdr_crd) - {11'd0, sop_hs} + {11'd0, hdr_crd_ret_i};
        dat_sum  = 12'(dat_crd) - dat_take + {8'd0, dat_crd_ret_i};
        hdr_ovf  = hdr_sum > 12'(HDR_CRD_MAX);
        dat_ovf  = dat_sum > 12'(DAT_CRD_MAX);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            remaining    <= 8'd0;
            hdr_crd      <= CRD_W'(HDR_CRD_MAX);
            dat_crd      <= CRD_W'(DAT_CRD_MAX);
            ovf_sticky   <= 1'b0;
            empty_sticky <= 1'b0;
        end else begin
            hdr_crd <= hdr_ovf ? CRD_W'(HDR_CRD_MAX) : hdr_sum[CRD_W-1:0];
            dat_crd <= dat_ovf ? CRD_W'(DAT_CRD_MAX) : dat_sum[CRD_W-1:0];
            if (hdr_ovf || dat_ovf) begin
                ovf_sticky <= 1'b1;
            end
            if ((state == XFER) && fifo_empty_i) begin
                empty_sticky <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (sop_hs && (pay_beats != 11'd0)) begin
                        // beats - 1 equals the payload beat count
                        remaining <= pay_beats[7:0];
                        state     <= XFER;
                    end
                end
                XFER: begin
                    if (hs) begin
                        remaining <= remaining - 8'd1;
                        if (remaining == 8'd1) begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    logic [15:0] stats;

`ifdef TL_TX_DRAIN_STATS_EN
    logic [7:0] pkt_cnt;
    logic [7:0] blk_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            pkt_cnt <= 8'd0;
            blk_cnt <= 8'd0;
        end else begin
            if (eop_hs) begin
                pkt_cnt <= pkt_cnt + 8'd1;
            end
            if (blocked && (blk_cnt != 8'hFF)) begin
                blk_cnt <= blk_cnt + 8'd1;
            end
        end
    end

    assign stats = {pkt_cnt, blk_cnt};
`else
    logic unused_eop_hs;
    assign unused_eop_hs = eop_hs;
    assign stats = 16'd0;
`endif

    assign hdr_crd_o = hdr_crd;
    assign dat_crd_o = dat_crd;
    assign debug_o   = {(state == XFER), blocked, ovf_sticky, empty_sticky,
                        4'd0, remaining, stats};

endmodule

// File: tb/tb_tl_tx_pkt_drain.sv
module tb_tl_tx_pkt_drain;
  localparam int DW = 256;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          fifo_empty;
  logic          fifo_rden;
  logic [DW-1:0] fifo_rdata;
  logic          tx_valid;
  logic          tx_ready;
  logic [DW-1:0] tx_data;
  logic          tx_sop;
  logic          tx_eop;
  logic          hdr_crd_ret;
  logic [3:0]    dat_crd_ret;
  logic [7:0]    hdr_crd;
  logic [7:0]    dat_crd;
  logic [31:0]   debug;

  tl_tx_pkt_drain dut (
    .clk          (clk),
    .rst          (rst),
    .fifo_empty_i (fifo_empty),
    .fifo_rden_o  (fifo_rden),
    .fifo_rdata_i (fifo_rdata),
    .tx_valid_o   (tx_valid),
    .tx_ready_i   (tx_ready),
    .tx_data_o    (tx_data),
    .tx_sop_o     (tx_sop),
    .tx_eop_o     (tx_eop),
    .hdr_crd_ret_i(hdr_crd_ret),
    .dat_crd_ret_i(dat_crd_ret),
    .hdr_crd_o    (hdr_crd),
    .dat_crd_o    (dat_crd),
    .debug_o      (debug)
  );

  // scoreboard counters
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // headers: bit30 = has_data, [9:0] = len_dw
  localparam logic [31:0] H_NODATA = 32'h0000_0000;
  localparam logic [31:0] H_L20    = 32'h4000_0014; // 3 payload beats
  localparam logic [31:0] H_L16    = 32'h4000_0010; // 2 payload beats
  localparam logic [31:0] H_L0     = 32'h4000_0000; // 1024 DW -> 128 beats
  localparam logic [31:0] H_L432   = 32'h4000_01B0; // 54 payload beats

  typedef struct {
    logic        empty;
    logic [31:0] hdr;
    logic        ready;
    logic        hret;
    logic [3:0]  dret;
    logic        e_valid;
    logic        e_rden;
    logic        e_sop;
    logic        e_eop;
    logic [3:0]  e_dbg;   // debug[31:28] before the edge
    logic [7:0]  e_hdr;   // after the edge
    logic [7:0]  e_dat;
    logic [7:0]  e_rem;
  } vec_t;

  vec_t vecs[20];

  initial begin
    // empty hdr rdy hret dret | v rd sop eop dbg | hdr dat rem
    vecs[0]  = '{1'b1, H_NODATA, 1'b1, 1'b0, 4'd0,  1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 8'd8, 8'd64, 8'd0};
    vecs[1]  = '{1'b0, H_NODATA, 1'b1, 1'b0, 4'd0,  1'b1, 1'b1, 1'b1, 1'b1, 4'b0000, 8'd7, 8'd64, 8'd0};
    vecs[2]  = '{1'b0, H_L20,    1'b0, 1'b0, 4'd0,  1'b1, 1'b0, 1'b1, 1'b0, 4'b0000, 8'd7, 8'd64, 8'd0};
    vecs[3]  = '{1'b0, H_L20,    1'b1, 1'b0, 4'd0,  1'b1, 1'b1, 1'b1, 1'b0, 4'b0000, 8'd6, 8'd61, 8'd3};
    vecs[4]  = '{1'b0, 32'h1111, 1'b1, 1'b0, 4'd0,  1'b1, 1'b1, 1'b0, 1'b0, 4'b1000, 8'd6, 8'd61, 8'd2};
    vecs[5]  = '{1'b0, 32'h2222, 1'b0, 1'b0, 4'd0,  1'b1, 1'b0, 1'b0, 1'b0, 4'b1000, 8'd6, 8'd61, 8'd2};
    vecs[6]  = '{1'b0, 32'h2222, 1'b1, 1'b0, 4'd0,  1'b1, 1'b1, 1'b0, 1'b0, 4'b1000, 8'd6, 8'd61, 8'd1};
    vecs[7]  = '{1'b0, 32'h3333, 1'b1, 1'b0, 4'd0,  1'b1, 1'b1, 1'b0, 1'b1, 4'b1000, 8'd6, 8'd61, 8'd0};
    vecs[8]  = '{1'b1, H_NODATA, 1'b1, 1'b1, 4'd3,  1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 8'd7, 8'd64, 8'd0};
    vecs[9]  = '{1'b0, H_L16,    1'b1, 1'b0, 4'd0,  1'b1, 1'b1, 1'b1, 1'b0, 4'b0000, 8'd6, 8'd62, 8'd2};
    vecs[10] = '{1'b1, 32'h4444, 1'b1, 1'b0, 4'd0,  1'b0, 1'b0, 1'b0, 1'b0, 4'b1000, 8'd6, 8'd62, 8'd2};
    vecs[11] = '{1'b1, 32'h4444, 1'b1, 1'b0, 4'd0,  1'b0, 1'b0, 1'b0, 1'b0, 4'b1001, 8'd6, 8'd62, 8'd2};
    vecs[12] = '{1'b0, 32'h5555, 1'b1, 1'b0, 4'd0,  1'b1, 1'b1, 1'b0, 1'b0, 4'b1001, 8'd6, 8'd62, 8'd1};
    vecs[13] = '{1'b0, 32'h6666, 1'b1, 1'b0, 4'd0,  1'b1, 1'b1, 1'b0, 1'b1, 4'b1001, 8'd6, 8'd62, 8'd0};
    vecs[14] = '{1'b0, H_L16,    1'b1, 1'b1, 4'd2,  1'b1, 1'b1, 1'b1, 1'b0, 4'b0001, 8'd6, 8'd62, 8'd2};
    vecs[15] = '{1'b0, 32'h7777, 1'b1, 1'b0, 4'd0,  1'b1, 1'b1, 1'b0, 1'b0, 4'b1001, 8'd6, 8'd62, 8'd1};
    vecs[16] = '{1'b0, 32'h8888, 1'b1, 1'b0, 4'd0,  1'b1, 1'b1, 1'b0, 1'b1, 4'b1001, 8'd6, 8'd62, 8'd0};
    vecs[17] = '{1'b0, H_L0,     1'b1, 1'b0, 4'd15, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0101, 8'd6, 8'd64, 8'd0};
    vecs[18] = '{1'b0, H_L0,     1'b1, 1'b0, 4'd0,  1'b0, 1'b0, 1'b0, 1'b0, 4'b0111, 8'd6, 8'd64, 8'd0};
    vecs[19] = '{1'b1, H_L0,     1'b1, 1'b1, 4'd0,  1'b0, 1'b0, 1'b0, 1'b0, 4'b0011, 8'd7, 8'd64, 8'd0};
  end

  // driver helper: present a head word with the given header in DW0
  task automatic drive(input logic empty, input logic [31:0] hdr, input logic ready,
                       input logic hret, input logic [3:0] dret);
    fifo_empty  = empty;
    fifo_rdata  = {224'd0, hdr};
    tx_ready    = ready;
    hdr_crd_ret = hret;
    dat_crd_ret = dret;
  endtask

  initial begin
    logic [DW-1:0] word;

    rst = 1'b1;
    drive(1'b1, 32'd0, 1'b1, 1'b0, 4'd0);
    tick();
    tick();
    #1;
    // reset state
    chk("rst_valid", DW'(tx_valid), DW'(1'b0));
    chk("rst_rden",  DW'(fifo_rden), DW'(1'b0));
    chk("rst_hdr",   DW'(hdr_crd), DW'(8'd8));
    chk("rst_dat",   DW'(dat_crd), DW'(8'd64));
    chk("rst_debug", DW'(debug), DW'(32'd0));
    rst = 1'b0;

    // table-driven main sequence
    for (int i = 0; i < 20; i++) begin
      drive(vecs[i].empty, vecs[i].hdr, vecs[i].ready, vecs[i].hret, vecs[i].dret);
      #1;
      chk($sformatf("v%0d_valid", i), DW'(tx_valid),    DW'(vecs[i].e_valid));
      chk($sformatf("v%0d_rden", i),  DW'(fifo_rden),   DW'(vecs[i].e_rden));
      chk($sformatf("v%0d_sop", i),   DW'(tx_sop),      DW'(vecs[i].e_sop));
      chk($sformatf("v%0d_eop", i),   DW'(tx_eop),      DW'(vecs[i].e_eop));
      chk($sformatf("v%0d_dbg", i),   DW'(debug[31:28]), DW'(vecs[i].e_dbg));
      tick();
      chk($sformatf("v%0d_hdr", i),   DW'(hdr_crd),      DW'(vecs[i].e_hdr));
      chk($sformatf("v%0d_dat", i),   DW'(dat_crd),      DW'(vecs[i].e_dat));
      chk($sformatf("v%0d_rem", i),   DW'(debug[23:16]), DW'(vecs[i].e_rem));
    end
`ifdef TL_TX_DRAIN_STATS_EN
    chk("stats", DW'(debug[15:0]), DW'({8'd4, 8'd2}));
`else
    chk("stats", DW'(debug[15:0]), DW'(16'd0));
`endif

    // long packet to bring dat_crd down to 10
    rst = 1'b1;
    drive(1'b1, 32'd0, 1'b1, 1'b0, 4'd0);
    tick();
    rst = 1'b0;
    drive(1'b0, H_L432, 1'b1, 1'b0, 4'd0);
    #1;
    chk("l432_sop", DW'({tx_valid, tx_sop, tx_eop}), DW'(3'b110));
    tick();
    chk("l432_dat", DW'(dat_crd), DW'(8'd10));
    chk("l432_rem", DW'(debug[23:16]), DW'(8'd54));
    for (int i = 0; i < 54; i++) begin
      word = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      fifo_rdata = word;
      #1;
      chk($sformatf("l432_data%0d", i), tx_data, word);
      chk($sformatf("l432_ctl%0d", i), DW'({fifo_rden, tx_sop, tx_eop}),
          DW'({1'b1, 1'b0, (i == 53)}));
      tick();
    end
    chk("l432_idle", DW'(debug[31]), DW'(1'b0));

    // simultaneous consume (2) and return (5) at dat_crd=10
    drive(1'b0, H_L16, 1'b1, 1'b0, 4'd5);
    tick();
    chk("net_dat", DW'(dat_crd), DW'(8'd13));
    chk("net_hdr", DW'(hdr_crd), DW'(8'd6));
    drive(1'b0, 32'h9999, 1'b1, 1'b0, 4'd0);
    tick();
    chk("xfer_before_rst", DW'(debug[31]), DW'(1'b1));

    // reset in the middle of XFER
    rst = 1'b1;
    tick();
    fifo_empty = 1'b1;
    #1;
    chk("xrst_valid", DW'(tx_valid), DW'(1'b0));
    chk("xrst_debug", DW'(debug), DW'(32'd0));
    chk("xrst_crd", DW'({hdr_crd, dat_crd}), DW'({8'd8, 8'd64}));
    rst = 1'b0;

    // header-credit exhaustion
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, H_NODATA, 1'b1, 1'b0, 4'd0);
      #1;
      chk($sformatf("nd%0d_ctl", i), DW'({fifo_rden, tx_sop, tx_eop}), DW'(3'b111));
      tick();
    end
    chk("hdr_zero", DW'(hdr_crd), DW'(8'd0));
    #1;
    chk("hdr_block", DW'({tx_valid, fifo_rden, debug[30]}), DW'(3'b001));
    hdr_crd_ret = 1'b1;
    #1;
    chk("hdr_ret_same_cycle", DW'(tx_valid), DW'(1'b0));
    tick();
    hdr_crd_ret = 1'b0;
    #1;
    chk("hdr_unblock", DW'({tx_valid, fifo_rden, debug[30]}), DW'(3'b110));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
